// File: rtl/ram_rd_pkg.sv
// -----------------------------------------------------------------------------
// ram_rd_pkg
//   Shared types and constants for the ram_stream_reader block.
//
//   Contents
//     DEF_RAM_WIDTH / DEF_ADDR_SIZE : default word width and address width
//     LEN_W                         : width of a transfer length (ADDR_SIZE+1,
//                                     so a full-RAM length is representable)
//     SKID_DEPTH / OCC_W            : skid buffer depth and occupancy width
//     rd_state_e                    : transfer FSM states
// -----------------------------------------------------------------------------
package ram_rd_pkg;

   localparam int DEF_RAM_WIDTH = 8;
   localparam int DEF_ADDR_SIZE = 4;

   // One extra bit so that a length equal to the full RAM depth fits.
   localparam int LEN_W = DEF_ADDR_SIZE + 1;

   // The buffer only has to absorb the single-cycle RAM read latency.
   localparam int SKID_DEPTH = 2;
   localparam int OCC_W      = $clog2(SKID_DEPTH + 1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      DONE
   } rd_state_e;

endpackage : ram_rd_pkg

// File: rtl/ram_stream_reader_if.sv
// -----------------------------------------------------------------------------
// ram_stream_reader_if
//   Valid/ready output stream of the RAM reader.
//
//   Signals
//     m_valid : word on m_data/m_last is valid
//     m_data  : stream word (RAM_WIDTH bits)
//     m_last  : marks the final word of a transfer
//     m_ready : consumer accepts the word this cycle
//
//   Modports
//     master : the reader (drives valid/data/last, samples ready)
//     slave  : the consumer (samples valid/data/last, drives ready)
// -----------------------------------------------------------------------------
interface ram_stream_reader_if
   import ram_rd_pkg::*;
#(
   parameter int RAM_WIDTH = DEF_RAM_WIDTH
);

   logic                 m_valid;
   logic [RAM_WIDTH-1:0] m_data;
   logic                 m_last;
   logic                 m_ready;

   modport master (
      output m_valid,
      output m_data,
      output m_last,
      input  m_ready
   );

   modport slave (
      input  m_valid,
      input  m_data,
      input  m_last,
      output m_ready
   );

endinterface : ram_stream_reader_if

// File: rtl/ram_rd_skid_buf.sv
// -----------------------------------------------------------------------------
// ram_rd_skid_buf
//   Two-entry FIFO holding {last, data} words returned by the RAM. Slot 0 is
//   always the head, so the head word is a plain register and stays stable
//   while the consumer stalls.
//
//   Ports
//     clk        : clock, rising edge
//     reset      : asynchronous active-high reset, empties the buffer
//     push       : write push_data this cycle
//     push_data  : {last, data} word to store
//     pop        : remove the head word this cycle
//     head_data  : {last, data} of the head word (stale when empty)
//     occupancy  : number of stored words, 0..SKID_DEPTH
// -----------------------------------------------------------------------------
module ram_rd_skid_buf
   import ram_rd_pkg::*;
#(
   parameter int WIDTH = DEF_RAM_WIDTH + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head_data,
   output logic [OCC_W-1:0] occupancy
);

   logic [WIDTH-1:0] slot0_q;
   logic [WIDTH-1:0] slot1_q;
   logic [OCC_W-1:0] occ_q;
   logic             pop_ok;
   logic             push_ok;

   // Guard both strobes so a misbehaving caller cannot underflow or overflow.
   assign pop_ok  = pop && (occ_q != '0);
   assign push_ok = push && ((occ_q != OCC_W'(SKID_DEPTH)) || pop_ok);

   // NOTE: storage slots are reset along with the count because the head slot
   // drives the output data port, which has to read 0 while in reset.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         slot0_q <= '0;
         slot1_q <= '0;
         occ_q   <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments so every slot
         // update below sees the values from before this edge.
         case ({push_ok, pop_ok})
            2'b10: begin
               if (occ_q == '0) begin
                  slot0_q <= push_data;
               end else begin
                  slot1_q <= push_data;
               end
               occ_q <= occ_q + OCC_W'(1);
            end
            2'b01: begin
               slot0_q <= slot1_q;
               occ_q   <= occ_q - OCC_W'(1);
            end
            2'b11: begin
               // Count is unchanged; the new word lands behind whatever
               // remains after the head leaves.
               if (occ_q == OCC_W'(1)) begin
                  slot0_q <= push_data;
               end else begin
                  slot0_q <= slot1_q;
                  slot1_q <= push_data;
               end
            end
            default: begin
            end
         endcase
      end
   end

   assign head_data = slot0_q;
   assign occupancy = occ_q;

endmodule : ram_rd_skid_buf

// File: rtl/ram_stream_reader.sv
// -----------------------------------------------------------------------------
// ram_stream_reader
//   Read-side engine for dual_port_ram. On a start command it reads a
//   contiguous (wrapping) block of RAM words and streams them out on a
//   valid/ready interface, absorbing the one-cycle RAM read latency in a
//   two-entry skid buffer.
//
//   Ports
//     clk          : clock, rising edge
//     reset        : asynchronous active-high reset
//     start        : command strobe, only looked at while idle
//     base_addr    : first RAM address of the transfer
//     length       : number of words; 0 is a no-op, above RAM_DEPTH clamps
//     busy         : transfer in progress (cycle after start up to done)
//     done         : one-cycle completion pulse
//     ram_read_en  : RAM read enable
//     ram_rd_addr  : RAM read address, holds its value between reads
//     ram_data_in  : RAM read data, valid the cycle after ram_read_en
//     m_stream     : output stream (master side of ram_stream_reader_if)
// -----------------------------------------------------------------------------
module ram_stream_reader
   import ram_rd_pkg::*;
#(
   parameter int RAM_WIDTH = DEF_RAM_WIDTH,
   parameter int ADDR_SIZE = DEF_ADDR_SIZE,
   parameter int RAM_DEPTH = 2 ** ADDR_SIZE
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [ADDR_SIZE-1:0] base_addr,
   input  logic [ADDR_SIZE:0]   length,
   output logic                 busy,
   output logic                 done,
   output logic                 ram_read_en,
   output logic [ADDR_SIZE-1:0] ram_rd_addr,
   input  logic [RAM_WIDTH-1:0] ram_data_in,
   ram_stream_reader_if.master  m_stream
);

   localparam int LW = ADDR_SIZE + 1;
   localparam logic [LW-1:0] DEPTH_L = LW'(RAM_DEPTH);

   rd_state_e state_q;
   rd_state_e state_d;

   logic [ADDR_SIZE-1:0] base_q;
   logic [LW-1:0]        len_q;
   logic [LW-1:0]        issued_q;
   logic [ADDR_SIZE-1:0] addr_q;
   logic                 inflight_q;
   logic                 inflight_last_q;

   logic [LW-1:0]        eff_len;
   logic [ADDR_SIZE-1:0] issue_addr;
   logic                 issue_last;
   logic                 room;
   logic                 pop;
   logic                 drain_empty;
   logic [OCC_W-1:0]     occ;
   logic [RAM_WIDTH:0]   head;

   // ---------------------------------------------------------------------------
   // Datapath helpers
   // ---------------------------------------------------------------------------
   assign eff_len = (length > DEPTH_L) ? DEPTH_L : length;

   // Addition truncates to ADDR_SIZE bits, giving the modulo-depth wrap.
   assign issue_addr = base_q + issued_q[ADDR_SIZE-1:0];
   assign issue_last = (issued_q == (len_q - LW'(1)));

   assign pop = m_stream.m_valid && m_stream.m_ready;

   // A new read is allowed only if, after this cycle's pop, the words already
   // buffered plus the one still coming back from the RAM leave a free slot.
   // pop implies occ >= 1, so the subtraction never goes negative.
   assign room = (({1'b0, occ} + {{OCC_W{1'b0}}, inflight_q}
                  - {{OCC_W{1'b0}}, pop}) < (OCC_W + 1)'(SKID_DEPTH));

   // Everything has left once nothing is returning from the RAM and the
   // buffer empties with this cycle's pop.
   assign drain_empty = !inflight_q &&
                        ((occ == '0) || ((occ == OCC_W'(1)) && pop));

   // ---------------------------------------------------------------------------
   // FSM: state register
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM: next state and read enable
   // ---------------------------------------------------------------------------
   always_comb begin
      // NOTE: every output of this block gets a default first, so no path
      // through the case can leave one unassigned and infer a latch.
      state_d     = state_q;
      ram_read_en = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = (eff_len == '0) ? DONE : RUN;
            end
         end
         RUN: begin
            ram_read_en = room;
            if (room && issue_last) begin
               state_d = DRAIN;
            end
         end
         DRAIN: begin
            if (drain_empty) begin
               state_d = DONE;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // Transfer bookkeeping
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         base_q          <= '0;
         len_q           <= '0;
         issued_q        <= '0;
         addr_q          <= '0;
         inflight_q      <= 1'b0;
         inflight_last_q <= 1'b0;
      end else begin
         inflight_q <= ram_read_en;
         if (ram_read_en) begin
            issued_q        <= issued_q + LW'(1);
            addr_q          <= issue_addr;
            inflight_last_q <= issue_last;
         end
         if ((state_q == IDLE) && start) begin
            base_q   <= base_addr;
            len_q    <= eff_len;
            issued_q <= '0;
         end
      end
   end

   // The live address is shown while reading; otherwise the last issued one
   // is held so the RAM port does not toggle between reads.
   assign ram_rd_addr = ram_read_en ? issue_addr : addr_q;

   // ---------------------------------------------------------------------------
   // Skid buffer: captures RAM data the cycle after each read
   // ---------------------------------------------------------------------------
   ram_rd_skid_buf #(
      .WIDTH (RAM_WIDTH + 1)
   ) u_skid (
      .clk       (clk),
      .reset     (reset),
      .push      (inflight_q),
      .push_data ({inflight_last_q, ram_data_in}),
      .pop       (pop),
      .head_data (head),
      .occupancy (occ)
   );

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign m_stream.m_valid = (occ != '0);
   assign m_stream.m_data  = head[RAM_WIDTH-1:0];
   assign m_stream.m_last  = head[RAM_WIDTH];

   assign busy = (state_q == RUN) || (state_q == DRAIN);
   assign done = (state_q == DONE);

endmodule : ram_stream_reader

// File: tb/tb_ram_stream_reader.sv
// -----------------------------------------------------------------------------
// tb_ram_stream_reader
//   Self-checking bench for ram_stream_reader. A behavioural RAM holding
//   mem[i] = i+1 answers reads one cycle late. Expected words and read
//   addresses are queued when a transfer is started and consumed as the DUT
//   issues reads and hands off words.
// -----------------------------------------------------------------------------
module tb_ram_stream_reader;
   import ram_rd_pkg::*;

   localparam int AW    = 4;
   localparam int DW    = 8;
   localparam int DEPTH = 16;

   typedef struct packed {
      logic          last;
      logic [DW-1:0] data;
   } beat_t;

   logic             clk = 1'b0;
   logic             reset;
   logic             start;
   logic [AW-1:0]    base_addr;
   logic [LEN_W-1:0] length;
   logic             busy;
   logic             done;
   logic             ram_read_en;
   logic [AW-1:0]    ram_rd_addr;
   logic [DW-1:0]    ram_q;

   ram_stream_reader_if #(.RAM_WIDTH(DW)) sif ();

   ram_stream_reader #(
      .RAM_WIDTH (DW),
      .ADDR_SIZE (AW),
      .RAM_DEPTH (DEPTH)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .start       (start),
      .base_addr   (base_addr),
      .length      (length),
      .busy        (busy),
      .done        (done),
      .ram_read_en (ram_read_en),
      .ram_rd_addr (ram_rd_addr),
      .ram_data_in (ram_q),
      .m_stream    (sif.master)
   );

   always #5 clk = ~clk;

   // Behavioural RAM read port: one cycle of latency.
   logic [DW-1:0] mem [DEPTH];
   initial begin
      for (int i = 0; i < DEPTH; i++) mem[i] = DW'(i + 1);
   end
   always @(posedge clk) begin
      if (ram_read_en) ram_q <= mem[ram_rd_addr];
   end

   // ---------------------------------------------------------------------------
   // Scoreboard state and check helper
   // ---------------------------------------------------------------------------
   int            checks = 0;
   int            errors = 0;
   beat_t         exp_q[$];
   logic [AW-1:0] addr_q[$];
   int            outstanding = 0;
   logic [AW-1:0] last_addr = '0;
   logic          stalled_prev = 1'b0;
   beat_t         stalled_beat = '0;
   logic          done_due = 1'b0;
   logic          allow_done = 1'b0;
   int            beats = 0;

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Monitor: samples on the falling edge, away from the active edge
   // ---------------------------------------------------------------------------
   always @(negedge clk) begin
      beat_t         exp_b;
      logic [AW-1:0] exp_a;
      logic          pop;
      if (reset) begin
         exp_q.delete();
         addr_q.delete();
         outstanding  = 0;
         last_addr    = '0;
         stalled_prev = 1'b0;
         done_due     = 1'b0;
      end else begin
         if (done_due) begin
            check("done_after_last", 32'(done), 32'd1);
            check("busy_low_at_done", 32'(busy), 32'd0);
         end else if (!allow_done) begin
            check("no_spurious_done", 32'(done), 32'd0);
         end

         check("occ_plus_inflight_le_2", 32'(outstanding <= 2), 32'd1);

         if (ram_read_en) begin
            check("read_expected", 32'(addr_q.size() > 0), 32'd1);
            if (addr_q.size() > 0) begin
               exp_a = addr_q.pop_front();
               check("rd_addr", 32'(ram_rd_addr), 32'(exp_a));
               last_addr = exp_a;
            end
         end else begin
            check("rd_addr_hold", 32'(ram_rd_addr), 32'(last_addr));
         end

         if (stalled_prev) begin
            check("stall_valid_held", 32'(sif.m_valid), 32'd1);
            check("stall_word_held", 32'({sif.m_last, sif.m_data}),
                  32'(stalled_beat));
         end

         pop      = sif.m_valid && sif.m_ready;
         done_due = 1'b0;
         if (pop) begin
            check("beat_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
               exp_b = exp_q.pop_front();
               check("beat_word", 32'({sif.m_last, sif.m_data}), 32'(exp_b));
               done_due = exp_b.last;
            end
            beats++;
         end

         outstanding  = outstanding + int'(ram_read_en) - int'(pop);
         stalled_prev = sif.m_valid && !sif.m_ready;
         stalled_beat = {sif.m_last, sif.m_data};
      end
   end

   // ---------------------------------------------------------------------------
   // Stimulus helpers
   // ---------------------------------------------------------------------------
   // Drives start for exactly one edge (E0) and queues the expected result.
   // Returns 1 time unit after E0.
   task automatic start_xfer(input logic [AW-1:0] b, input logic [LEN_W-1:0] l);
      int eff;
      int a;
      eff = (int'(l) > DEPTH) ? DEPTH : int'(l);
      @(posedge clk); #1;
      start     = 1'b1;
      base_addr = b;
      length    = l;
      for (int i = 0; i < eff; i++) begin
         a = (int'(b) + i) % DEPTH;
         addr_q.push_back(AW'(a));
         exp_q.push_back({(i == eff - 1), DW'(a + 1)});
      end
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Applies a repeating 8-cycle m_ready pattern (bit 0 first) until done.
   task automatic run_until_done(input int budget, input logic [7:0] pat);
      int   n;
      logic seen;
      n    = 0;
      seen = 1'b0;
      while ((n < budget) && !seen) begin
         sif.m_ready = pat[n % 8];
         @(negedge clk);
         seen = done;
         n++;
         @(posedge clk); #1;
      end
      check("done_within_budget", 32'(seen), 32'd1);
      check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      check("reads_drained", 32'(addr_q.size()), 32'd0);
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"},  32'(busy), 32'd0);
      check({tag, "_done"},  32'(done), 32'd0);
      check({tag, "_rd_en"}, 32'(ram_read_en), 32'd0);
      check({tag, "_addr"},  32'(ram_rd_addr), 32'd0);
      check({tag, "_valid"}, 32'(sif.m_valid), 32'd0);
      check({tag, "_data"},  32'(sif.m_data), 32'd0);
      check({tag, "_last"},  32'(sif.m_last), 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------------------------------------------------------------------
   // Directed sequence
   // ---------------------------------------------------------------------------
   initial begin
      int b0;
      int n;

      reset       = 1'b0;
      start       = 1'b0;
      base_addr   = '0;
      length      = '0;
      sif.m_ready = 1'b0;
      #2 reset = 1'b1;
      #1 check_all_zero("reset");
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      // 1: full RAM, no backpressure, latency and back-to-back beats.
      sif.m_ready = 1'b1;
      start_xfer(4'd0, 5'd16);
      @(negedge clk);
      check("t1_rd_en_after_e0", 32'(ram_read_en), 32'd1);
      check("t1_busy_after_e0", 32'(busy), 32'd1);
      check("t1_valid_c1", 32'(sif.m_valid), 32'd0);
      @(negedge clk);
      check("t1_valid_c2", 32'(sif.m_valid), 32'd0);
      @(negedge clk);
      check("t1_valid_c3", 32'(sif.m_valid), 32'd1);
      for (int i = 1; i < 16; i++) begin
         @(negedge clk);
         check("t1_valid_consecutive", 32'(sif.m_valid), 32'd1);
      end
      @(negedge clk);
      check("t1_done_pulse", 32'(done), 32'd1);
      @(negedge clk);
      check("t1_done_one_cycle", 32'(done), 32'd0);
      check("t1_busy_after", 32'(busy), 32'd0);
      check("t1_queue_empty", 32'(exp_q.size()), 32'd0);
      @(posedge clk); #1;

      // 2: wrap-around addressing.
      start_xfer(4'd14, 5'd4);
      run_until_done(50, 8'hFF);

      // 3: backpressure pattern 1,0,0,1,0,1,1,0.
      start_xfer(4'd3, 5'd5);
      run_until_done(200, 8'b0110_1001);

      // 4a: zero length is a no-op that still pulses done.
      allow_done = 1'b1;
      start_xfer(4'd5, 5'd0);
      @(negedge clk);
      check("t4_zero_done", 32'(done), 32'd1);
      check("t4_zero_busy", 32'(busy), 32'd0);
      check("t4_zero_rd_en", 32'(ram_read_en), 32'd0);
      check("t4_zero_valid", 32'(sif.m_valid), 32'd0);
      @(negedge clk);
      check("t4_zero_done_one_cycle", 32'(done), 32'd0);
      @(posedge clk); #1;
      allow_done = 1'b0;

      // 4b: oversized length clamps to the RAM depth.
      b0 = beats;
      start_xfer(4'd0, 5'd20);
      run_until_done(100, 8'hFF);
      check("t4_clamp_beats", 32'(beats - b0), 32'd16);

      // 5: start while busy is ignored.
      b0 = beats;
      start_xfer(4'd2, 5'd6);
      sif.m_ready = 1'b0;
      start       = 1'b1;
      base_addr   = 4'd9;
      length      = 5'd3;
      repeat (3) @(posedge clk);
      #1 start = 1'b0;
      run_until_done(100, 8'b1101_0110);
      check("t5_beats", 32'(beats - b0), 32'd6);
      repeat (3) @(posedge clk);
      #1 check("t5_idle_after", 32'(busy), 32'd0);

      // 6: reset in the middle of a transfer, then a fresh one.
      sif.m_ready = 1'b1;
      b0 = beats;
      start_xfer(4'd0, 5'd16);
      n = 0;
      while ((beats < b0 + 3) && (n < 50)) begin
         @(posedge clk);
         n++;
      end
      check("t6_three_beats_seen", 32'(beats - b0), 32'd3);
      #1 reset = 1'b1;
      #1 check_all_zero("t6_reset");
      @(negedge clk);
      @(posedge clk); #1;
      reset = 1'b0;
      b0 = beats;
      start_xfer(4'd8, 5'd2);
      run_until_done(50, 8'hFF);
      check("t6_new_beats", 32'(beats - b0), 32'd2);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_ram_stream_reader
